// File: rtl/game_judge.sv
// game_judge: collision referee for a maze chase game.
// Compares the player against every ghost each cycle, registers the result,
// and runs the life / freeze / game-over sequencing that the player and
// ghost controllers follow through the hit, respawn and freeze outputs.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; lives preloaded, collisions ignored
//   PLAY   | game running; a registered collision costs a life
//   FREEZE | post-hit pause; counter runs down, collisions ignored
//   OVER   | no lives left; waiting for start to begin a new game
module game_judge #(
  parameter int NUM_GHOSTS    = 4,
  parameter int HIT_DIST      = 10,
  parameter int LIVES         = 3,
  parameter int FREEZE_CYCLES = 60,
  parameter int LW            = $clog2(LIVES + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [9:0]              Player_x,
  input  logic [8:0]              Player_y,
  input  logic [10*NUM_GHOSTS-1:0] Ghost_x,
  input  logic [9*NUM_GHOSTS-1:0] Ghost_y,
  output logic                    isOver,
  output logic [LW-1:0]           lives,
  output logic                    hit,
  output logic                    respawn,
  output logic                    freeze,
  output logic [1:0]              state
);

  // The freeze counter only has to hold FREEZE_CYCLES-1; keep at least one bit.
  localparam int CW = (FREEZE_CYCLES > 1) ? $clog2(FREEZE_CYCLES) : 1;

  localparam logic [LW-1:0] LIVES_INIT  = LW'(LIVES);
  localparam logic [CW-1:0] FREEZE_LOAD = CW'(FREEZE_CYCLES - 1);
  localparam logic [9:0]    HIT_X       = 10'(HIT_DIST);
  localparam logic [8:0]    HIT_Y       = 9'(HIT_DIST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    FREEZE = 2'd2,
    OVER   = 2'd3
  } state_t;

  state_t          st_q, st_d;
  logic [LW-1:0]   lives_q, lives_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hit_q, hit_d;
  logic            respawn_q, respawn_d;
  logic            freeze_q;
  logic            over_q;
  logic            guard_q, guard_d;
  logic            collide_q;
  logic            collide_any;
  logic [NUM_GHOSTS-1:0] ghost_hit;

  // Magnitude difference: larger minus smaller, so no modular wraparound
  // can turn two distant coordinates into a false near miss.
  function automatic logic [9:0] abs_diff_x(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [8:0] abs_diff_y(input logic [8:0] a, input logic [8:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Per-ghost collision: aligned on one axis and within HIT_DIST on the other.
  genvar g;
  generate
    for (g = 0; g < NUM_GHOSTS; g++) begin : g_ghost
      logic [9:0] gx;
      logic [8:0] gy;
      logic       same_x, same_y;
      logic       near_x, near_y;
      assign gx     = Ghost_x[10*g +: 10];
      assign gy     = Ghost_y[9*g +: 9];
      assign same_x = (gx == Player_x);
      assign same_y = (gy == Player_y);
      assign near_x = (abs_diff_x(gx, Player_x) <= HIT_X);
      assign near_y = (abs_diff_y(gy, Player_y) <= HIT_Y);
      assign ghost_hit[g] = (same_x && near_y) || (same_y && near_x);
    end
  endgenerate

  assign collide_any = |ghost_hit;

  // Register the collision OR every cycle regardless of state.
  always_ff @(posedge clk) begin
    if (reset) begin
      collide_q <= 1'b0;
    end else begin
      collide_q <= collide_any;
    end
  end

  // Next-state and next-output logic for the game sequencer.
  always_comb begin
    st_d      = st_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    hit_d     = 1'b0;
    respawn_d = 1'b0;
    guard_d   = 1'b0;
    case (st_q)
      IDLE: begin
        if (start) begin
          st_d      = PLAY;
          lives_d   = LIVES_INIT;
          respawn_d = 1'b1;
          guard_d   = 1'b1;
        end
      end
      PLAY: begin
        // The first PLAY cycle after a respawn ignores collide_q, giving
        // the controllers a cycle to reload positions.
        if (collide_q && !guard_q) begin
          hit_d = 1'b1;
          if (lives_q > LW'(1)) begin
            st_d    = FREEZE;
            lives_d = lives_q - LW'(1);
            cnt_d   = FREEZE_LOAD;
          end else begin
            st_d    = OVER;
            lives_d = '0;
          end
        end
      end
      FREEZE: begin
        if (cnt_q == '0) begin
          st_d      = PLAY;
          respawn_d = 1'b1;
          guard_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      OVER: begin
        lives_d = '0;
        if (start) begin
          st_d      = PLAY;
          lives_d   = LIVES_INIT;
          respawn_d = 1'b1;
          guard_d   = 1'b1;
        end
      end
      default: begin
        st_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= IDLE;
      lives_q   <= LIVES_INIT;
      cnt_q     <= '0;
      hit_q     <= 1'b0;
      respawn_q <= 1'b0;
      guard_q   <= 1'b0;
      freeze_q  <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      lives_q   <= lives_d;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
      respawn_q <= respawn_d;
      guard_q   <= guard_d;
      freeze_q  <= (st_d == FREEZE);
      over_q    <= (st_d == OVER);
    end
  end

  assign state   = st_q;
  assign lives   = lives_q;
  assign hit     = hit_q;
  assign respawn = respawn_q;
  assign freeze  = freeze_q;
  assign isOver  = over_q;

endmodule

// File: tb/tb_game_judge.sv
// Directed testbench for game_judge with default parameters.
module tb_game_judge;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  Player_x;
  logic [8:0]  Player_y;
  logic [39:0] Ghost_x;
  logic [35:0] Ghost_y;
  logic        isOver;
  logic [1:0]  lives;
  logic        hit;
  logic        respawn;
  logic        freeze;
  logic [1:0]  state;

  int checks;
  int failures;

  game_judge dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .Player_x (Player_x),
    .Player_y (Player_y),
    .Ghost_x  (Ghost_x),
    .Ghost_y  (Ghost_y),
    .isOver   (isOver),
    .lives    (lives),
    .hit      (hit),
    .respawn  (respawn),
    .freeze   (freeze),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ghost(input int i, input logic [9:0] x, input logic [8:0] y);
    Ghost_x[10*i +: 10] = x;
    Ghost_y[9*i +: 9]   = y;
  endtask

  task automatic ghosts_far();
    set_ghost(0, 10'd500, 9'd400);
    set_ghost(1, 10'd600, 9'd300);
    set_ghost(2, 10'd300, 9'd450);
    set_ghost(3, 10'd400, 9'd200);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    Player_x = 10'd100;
    Player_y = 9'd100;
    ghosts_far();
    tick(3);
    reset = 1'b0;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (lives !== 2'd3) begin failures++; $display("FAIL reset_lives got=%0d exp=3", lives); end
    checks++; if ({isOver, hit, respawn, freeze} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {isOver, hit, respawn, freeze}); end
  endtask

  task automatic test_start();
    int nh;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL start_state got=%0d exp=1", state); end
    checks++; if (lives !== 2'd3) begin failures++; $display("FAIL start_lives got=%0d exp=3", lives); end
    checks++; if (respawn !== 1'b1 || hit !== 1'b0) begin failures++; $display("FAIL start_respawn got=%b%b exp=10", respawn, hit); end
    tick(1);
    checks++; if (respawn !== 1'b0) begin failures++; $display("FAIL start_respawn_width got=%b exp=0", respawn); end
    nh = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (hit) nh++;
    end
    checks++; if (nh !== 0 || state !== 2'd1) begin failures++; $display("FAIL start_nohit hits=%0d state=%0d exp 0/1", nh, state); end
  endtask

  task automatic test_hit_freeze();
    int nf;
    int nh;
    set_ghost(0, 10'd100, 9'd110);
    tick(1);
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL hit_latency got=%b exp=0", hit); end
    tick(1);
    ghosts_far();
    checks++; if (hit !== 1'b1 || lives !== 2'd2 || state !== 2'd2 || freeze !== 1'b1) begin
      failures++; $display("FAIL hit_response hit=%b lives=%0d state=%0d freeze=%b exp 1/2/2/1", hit, lives, state, freeze);
    end
    nf = 0;
    nh = 0;
    while (freeze === 1'b1 && nf < 100) begin
      nf++;
      tick(1);
      if (hit) nh++;
    end
    checks++; if (nf !== 60) begin failures++; $display("FAIL freeze_len got=%0d exp=60", nf); end
    checks++; if (respawn !== 1'b1 || state !== 2'd1 || nh !== 0) begin
      failures++; $display("FAIL freeze_exit respawn=%b state=%0d hits=%0d exp 1/1/0", respawn, state, nh);
    end
    tick(1);
    checks++; if (respawn !== 1'b0) begin failures++; $display("FAIL freeze_respawn_width got=%b exp=0", respawn); end
  endtask

  task automatic test_boundary();
    int nh;
    int w;
    set_ghost(0, 10'd100, 9'd111);
    nh = 0;
    for (int i = 0; i < 3; i++) begin tick(1); if (hit) nh++; end
    checks++; if (nh !== 0 || lives !== 2'd2) begin failures++; $display("FAIL bound_y11 hits=%0d lives=%0d exp 0/2", nh, lives); end
    set_ghost(0, 10'd89, 9'd100);
    nh = 0;
    for (int i = 0; i < 3; i++) begin tick(1); if (hit) nh++; end
    checks++; if (nh !== 0 || lives !== 2'd2) begin failures++; $display("FAIL bound_x11 hits=%0d lives=%0d exp 0/2", nh, lives); end
    set_ghost(0, 10'd90, 9'd100);
    tick(2);
    ghosts_far();
    checks++; if (hit !== 1'b1 || lives !== 2'd1 || state !== 2'd2) begin
      failures++; $display("FAIL bound_x10 hit=%b lives=%0d state=%0d exp 1/1/2", hit, lives, state);
    end
    w = 0;
    while (state !== 2'd1 && w < 100) begin tick(1); w++; end
    checks++; if (w >= 100) begin failures++; $display("FAIL bound_return timeout state=%0d exp=1", state); end
    tick(2);
    // Wraparound: 5 vs 1020 would be 9 modulo 1024; 3 vs 510 would be 5 modulo 512.
    Player_x = 10'd5;
    Player_y = 9'd100;
    set_ghost(0, 10'd1020, 9'd100);
    nh = 0;
    for (int i = 0; i < 3; i++) begin tick(1); if (hit) nh++; end
    checks++; if (nh !== 0) begin failures++; $display("FAIL wrap_x hits=%0d exp=0", nh); end
    Player_y = 9'd3;
    set_ghost(0, 10'd5, 9'd510);
    nh = 0;
    for (int i = 0; i < 3; i++) begin tick(1); if (hit) nh++; end
    checks++; if (nh !== 0 || lives !== 2'd1) begin failures++; $display("FAIL wrap_y hits=%0d lives=%0d exp 0/1", nh, lives); end
    Player_x = 10'd100;
    Player_y = 9'd100;
    ghosts_far();
    tick(2);
  endtask

  task automatic test_game_over_and_continuous();
    int nh;
    int nr;
    int both;
    int times[3];
    int lv[3];
    set_ghost(0, 10'd100, 9'd110);
    tick(2);
    checks++; if (hit !== 1'b1 || state !== 2'd3 || isOver !== 1'b1 || lives !== 2'd0) begin
      failures++; $display("FAIL over_entry hit=%b state=%0d isOver=%b lives=%0d exp 1/3/1/0", hit, state, isOver, lives);
    end
    tick(3);
    checks++; if (hit !== 1'b0 || state !== 2'd3 || lives !== 2'd0) begin
      failures++; $display("FAIL over_hold hit=%b state=%0d lives=%0d exp 0/3/0", hit, state, lives);
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checks++; if (state !== 2'd1 || lives !== 2'd3 || isOver !== 1'b0 || respawn !== 1'b1) begin
      failures++; $display("FAIL over_restart state=%0d lives=%0d isOver=%b respawn=%b exp 1/3/0/1", state, lives, isOver, respawn);
    end
    nh = 0; nr = 0; both = 0;
    for (int c = 1; c <= 200; c++) begin
      tick(1);
      if (hit && respawn) both++;
      if (respawn) nr++;
      if (hit) begin
        if (nh < 3) begin times[nh] = c; lv[nh] = int'(lives); end
        nh++;
      end
      if (state == 2'd3) break;
    end
    checks++; if (nh !== 3) begin failures++; $display("FAIL cont_hits got=%0d exp=3", nh); end
    if (nh >= 3) begin
      checks++; if (times[0] !== 2 || times[1] !== 64 || times[2] !== 126) begin
        failures++; $display("FAIL cont_spacing got=%0d,%0d,%0d exp=2,64,126", times[0], times[1], times[2]);
      end
      checks++; if (lv[0] !== 2 || lv[1] !== 1 || lv[2] !== 0) begin
        failures++; $display("FAIL cont_lives got=%0d,%0d,%0d exp=2,1,0", lv[0], lv[1], lv[2]);
      end
    end
    checks++; if (nr !== 2 || both !== 0) begin failures++; $display("FAIL cont_respawns got=%0d overlap=%0d exp 2/0", nr, both); end
    checks++; if (isOver !== 1'b1) begin failures++; $display("FAIL cont_over got=%b exp=1", isOver); end
    start = 1'b1;
    ghosts_far();
    tick(1);
    start = 1'b0;
    checks++; if (state !== 2'd1 || lives !== 2'd3 || isOver !== 1'b0) begin
      failures++; $display("FAIL cont_restart state=%0d lives=%0d isOver=%b exp 1/3/0", state, lives, isOver);
    end
    tick(3);
  endtask

  task automatic test_reset_in_freeze();
    int nr;
    set_ghost(0, 10'd100, 9'd110);
    tick(2);
    ghosts_far();
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL rf_enter state=%0d exp=2", state); end
    tick(19);
    checks++; if (freeze !== 1'b1) begin failures++; $display("FAIL rf_cycle20 freeze=%b exp=1", freeze); end
    reset = 1'b1;
    start = 1'b1;
    tick(1);
    checks++; if (state !== 2'd0 || lives !== 2'd3 || freeze !== 1'b0 || respawn !== 1'b0 || hit !== 1'b0) begin
      failures++; $display("FAIL rf_reset state=%0d lives=%0d freeze=%b respawn=%b hit=%b exp 0/3/0/0/0", state, lives, freeze, respawn, hit);
    end
    reset = 1'b0;
    start = 1'b0;
    nr = 0;
    for (int i = 0; i < 3; i++) begin tick(1); if (respawn) nr++; end
    checks++; if (nr !== 0 || state !== 2'd0) begin failures++; $display("FAIL rf_after respawns=%0d state=%0d exp 0/0", nr, state); end
  endtask

  task automatic test_ghost3_idle();
    int nh;
    set_ghost(3, 10'd100, 9'd95);
    nh = 0;
    for (int i = 0; i < 4; i++) begin tick(1); if (hit) nh++; end
    checks++; if (nh !== 0 || lives !== 2'd3 || state !== 2'd0) begin
      failures++; $display("FAIL idle_ignore hits=%0d lives=%0d state=%0d exp 0/3/0", nh, lives, state);
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checks++; if (state !== 2'd1 || respawn !== 1'b1 || hit !== 1'b0) begin
      failures++; $display("FAIL g3_start state=%0d respawn=%b hit=%b exp 1/1/0", state, respawn, hit);
    end
    tick(1);
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL g3_guard hit=%b exp=0", hit); end
    tick(1);
    checks++; if (hit !== 1'b1 || lives !== 2'd2 || state !== 2'd2) begin
      failures++; $display("FAIL g3_hit hit=%b lives=%0d state=%0d exp 1/2/2", hit, lives, state);
    end
    ghosts_far();
    tick(2);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    start = 1'b0;
    Player_x = 10'd100;
    Player_y = 9'd100;
    Ghost_x = '0;
    Ghost_y = '0;
    ghosts_far();
    test_reset();
    test_start();
    test_hit_freeze();
    test_boundary();
    test_game_over_and_continuous();
    test_reset_in_freeze();
    test_ghost3_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_judge.md
GAME_JUDGE -- requirements
Module: game_judge

Interface
REQ-001 Parameter NUM_GHOSTS, default 4: number of ghost position pairs checked.
REQ-002 Parameter HIT_DIST, default 10: collision tolerance in pixels along the shared axis.
REQ-003 Parameter LIVES, default 3: lives loaded at game start; LW = $clog2(LIVES+1).
REQ-004 Parameter FREEZE_CYCLES, default 60: cycles spent frozen after a non-fatal hit; must be >= 1.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  level; begins or restarts a game from IDLE or OVER.
REQ-008 Player_x  input  10  player pixel x.
REQ-009 Player_y  input  9  player pixel y.
REQ-010 Ghost_x  input  10*NUM_GHOSTS  ghost i x at bits [10i+9:10i].
REQ-011 Ghost_y  input  9*NUM_GHOSTS  ghost i y at bits [9i+8:9i].
REQ-012 isOver  output  1  high while in OVER.
REQ-013 lives  output  LW  remaining lives.
REQ-014 hit  output  1  one-cycle pulse per accepted collision.
REQ-015 respawn  output  1  one-cycle pulse commanding player/ghost controllers to reload start positions.
REQ-016 freeze  output  1  high while in FREEZE; controllers hold position.
REQ-017 state  output  2  IDLE=0, PLAY=1, FREEZE=2, OVER=3.

Function
REQ-018 Ghost i collides when (Ghost_x_i == Player_x and |Ghost_y_i - Player_y| <= HIT_DIST) or (Ghost_y_i == Player_y and |Ghost_x_i - Player_x| <= HIT_DIST).
REQ-019 Absolute differences use magnitude compare (larger minus smaller), never wrapped subtraction; coordinate 0 versus 639 yields 639.
REQ-020 collide_q registers the OR over all ghosts every cycle, in every state; an accepted hit's response is one cycle after the causing inputs.
REQ-021 IDLE: start=1 -> PLAY, lives <= LIVES, respawn pulses next cycle; otherwise remain; collide_q ignored.
REQ-022 PLAY with collide_q=1 and lives > 1 -> FREEZE, lives decrements by 1, hit pulses, freeze counter <= FREEZE_CYCLES-1.
REQ-023 PLAY with collide_q=1 and lives == 1 -> OVER, lives <= 0, hit pulses, isOver <= 1.
REQ-024 PLAY with collide_q=0: hold; start is ignored in PLAY.
REQ-025 FREEZE: counter decrements each cycle; collide_q ignored; when counter == 0 -> PLAY with a respawn pulse; total FREEZE residency is FREEZE_CYCLES cycles.
REQ-026 OVER: isOver held 1, lives held 0; start=1 -> PLAY, lives <= LIVES, isOver <= 0, respawn pulses.
REQ-027 In the cycle entering PLAY from IDLE, OVER or FREEZE, collide_q is ignored, giving one guard cycle after respawn.
REQ-028 hit and respawn are never high in the same cycle; each is high for exactly one cycle per event.
REQ-029 freeze = (state == FREEZE) and isOver = (state == OVER), both registered.
REQ-030 lives never underflows below 0 nor exceeds LIVES.

Reset
REQ-031 reset=1 at a clock edge forces state=IDLE, lives=LIVES, isOver=0, hit=0, respawn=0, freeze=0, counter=0, collide_q=0 in all states, including mid-FREEZE.
REQ-032 reset has priority over start and collide_q in the same cycle.

Verification
REQ-033 Reset, start=1 one cycle, Player=(100,100), ghosts far -> state=PLAY, lives=3, one respawn pulse, no hit.
REQ-034 In PLAY, Ghost0=(100,110), Player=(100,100) -> one cycle later hit=1, lives=2, state=FREEZE; freeze=1 for 60 cycles, then a respawn pulse and state=PLAY.
REQ-035 Boundary: Ghost0=(100,111) -> no hit; Ghost0=(89,100) -> no hit; Ghost0=(90,100) -> hit.
REQ-036 Collision held continuously from game start -> hits spaced 62 cycles apart (1 latency + 60 freeze + 1 guard), lives 3->2->1->0; third hit enters OVER with isOver=1; start=1 -> PLAY, lives=3, isOver=0.
REQ-037 reset=1 asserted during FREEZE cycle 20 -> next cycle state=IDLE, lives=3, freeze=0, no respawn pulse.
REQ-038 Ghost3 only colliding, Ghost0-2 far, NUM_GHOSTS=4 -> hit asserted; collision present while in IDLE -> no hit, lives unchanged.
